// File: rtl/rw_ready_seq.sv
// rw_ready_seq: round-robin N-channel read/write strobe sequencer with per-channel delayed ready.
// Define RW_SEQ_ASSERT_EN to embed the concurrent assertions.
module rw_ready_seq #(
  parameter int CHANNELS = 4,
  parameter int READY_LAT = 1,
  parameter int ID_W = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] ctrl,
  output logic [CHANNELS-1:0] read,
  output logic [CHANNELS-1:0] write,
  output logic [CHANNELS-1:0] ready,
  output logic [ID_W-1:0]     grant_id,
  output logic                active
);
  logic [ID_W-1:0] ptr, k, idx, nxt;
  logic gnt;
  logic [CHANNELS-1:0] oh;
  logic [CHANNELS-1:0] stg [READY_LAT];
  // scan from the far end back toward ptr so the nearest requester wins
  always_comb begin
    gnt = 1'b0;
    k = '0;
    idx = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      idx = ID_W'((int'(ptr) + j) % CHANNELS);
      if (req[idx]) begin
        gnt = 1'b1;
        k = idx;
      end
    end
    oh = CHANNELS'(1) << k;
    nxt = (int'(k) == CHANNELS - 1) ? '0 : k + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      read <= '0;
      write <= '0;
      grant_id <= '0;
      active <= 1'b0;
      ptr <= '0;
      for (int s = 0; s < READY_LAT; s++) stg[s] <= '0;
    end else begin
      read <= (gnt && !ctrl[k]) ? oh : '0;
      write <= (gnt && ctrl[k]) ? oh : '0;
      grant_id <= gnt ? k : grant_id;
      active <= gnt;
      ptr <= gnt ? nxt : ptr;
      stg[0] <= write;
      for (int s = 1; s < READY_LAT; s++) stg[s] <= stg[s-1];
    end
  end
  assign ready = stg[READY_LAT-1];
`ifdef RW_SEQ_ASSERT_EN
  a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(read | write));
  a_rw: assert property (@(posedge clock) disable iff (reset) !(|(read & write)));
  a_gid: assert property (@(posedge clock) disable iff (reset)
    active |-> (read[grant_id] | write[grant_id]));
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    a_wr: assert property (@(posedge clock) disable iff (reset)
      write[i] |-> ##READY_LAT ready[i]);
    a_rdy: assert property (@(posedge clock) disable iff (reset)
      ready[i] |-> $past(write[i], READY_LAT));
    a_fair: assert property (@(posedge clock) disable iff (reset)
      (req[i] && !(read[i] | write[i])) [*CHANNELS] |=> (read[i] | write[i]));
  end
`endif
endmodule

// File: tb/tb_rw_ready_seq.sv
// tb_rw_ready_seq: directed table, hand sequences and random stimulus against a reference model.
module tb_rw_ready_seq;
  localparam int N = 4;
  typedef struct {
    logic rst;
    logic [N-1:0] req, ctrl, rd, wr, rdy;
    logic [1:0] gid;
    logic act;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0, ctrl = '0;
  logic [N-1:0] rd1, wr1, rdy1, rd3, wr3, rdy3, rd4, wr4, rdy4;
  logic [1:0] gid1, gid3, gid4;
  logic act1, act3, act4;
  int n_chk = 0, n_fail = 0;
  int p;
  logic [N-1:0] m_rd, m_wr;
  logic [1:0] m_gid;
  logic m_act;
  logic [N-1:0] hist [8];
  vec_t tbl [$];
  always #5 clock = ~clock;
  rw_ready_seq #(.CHANNELS(N), .READY_LAT(1)) u1 (.clock(clock), .reset(reset), .req(req), .ctrl(ctrl),
    .read(rd1), .write(wr1), .ready(rdy1), .grant_id(gid1), .active(act1));
  rw_ready_seq #(.CHANNELS(N), .READY_LAT(3)) u3 (.clock(clock), .reset(reset), .req(req), .ctrl(ctrl),
    .read(rd3), .write(wr3), .ready(rdy3), .grant_id(gid3), .active(act3));
  rw_ready_seq #(.CHANNELS(N), .READY_LAT(4)) u4 (.clock(clock), .reset(reset), .req(req), .ctrl(ctrl),
    .read(rd4), .write(wr4), .ready(rdy4), .grant_id(gid4), .active(act4));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: one grant per cycle, nearest requester from the pointer, readies are delayed write history
  task automatic model(input logic r, input logic [N-1:0] q, input logic [N-1:0] c);
    int w;
    if (r) begin
      p = 0; m_rd = '0; m_wr = '0; m_gid = '0; m_act = 1'b0;
      for (int d = 0; d < 8; d++) hist[d] = '0;
    end else begin
      for (int d = 7; d > 0; d--) hist[d] = hist[d-1];
      hist[0] = m_wr;
      m_rd = '0; m_wr = '0; m_act = 1'b0;
      w = -1;
      for (int j = 0; j < N; j++) if (w < 0 && q[(p + j) % N]) w = (p + j) % N;
      if (w >= 0) begin
        m_act = 1'b1;
        m_gid = w[1:0];
        if (c[w]) m_wr[w] = 1'b1; else m_rd[w] = 1'b1;
        p = (w + 1) % N;
      end
    end
  endtask
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N-1:0] c);
    reset = r; req = q; ctrl = c;
    @(posedge clock);
    model(r, q, c);
    @(negedge clock);
    chk("read", rd1, m_rd);
    chk("write", wr1, m_wr);
    chk("grant_id", gid1, m_gid);
    chk("active", act1, m_act);
    chk("ready_l1", rdy1, hist[0]);
    chk("read_l3", rd3, m_rd);
    chk("write_l3", wr3, m_wr);
    chk("ready_l3", rdy3, hist[2]);
    chk("write_l4", wr4, m_wr);
    chk("ready_l4", rdy4, hist[3]);
    chk("rw_onehot0", $onehot0(rd1 | wr1), 1);
    chk("rw_disjoint", rd1 & wr1, 0);
  endtask
  initial begin
    tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 4'h0, 4'b0100, 4'h0, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'b0001, 4'h0, 4'h0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'b0010, 4'h0, 4'h0, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'b0100, 4'h0, 4'h0, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'b1000, 4'h0, 4'h0, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'b0001, 4'h0, 4'h0, 2'd0, 1'b1});
    @(negedge clock);
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].ctrl);
      chk($sformatf("tbl%0d_read", i), rd1, tbl[i].rd);
      chk($sformatf("tbl%0d_write", i), wr1, tbl[i].wr);
      chk($sformatf("tbl%0d_ready", i), rdy1, tbl[i].rdy);
      chk($sformatf("tbl%0d_gid", i), gid1, tbl[i].gid);
      chk($sformatf("tbl%0d_active", i), act1, tbl[i].act);
    end
    cyc(1'b1, 4'h0, 4'h0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, i <= 3 ? 4'b0010 : 4'h0, i <= 3 ? 4'b0010 : 4'h0);
      chk($sformatf("b2b_write_%0d", i), wr3, i <= 3 ? 4'b0010 : 4'h0);
      chk($sformatf("b2b_ready_%0d", i), rdy3, (i >= 4 && i <= 6) ? 4'b0010 : 4'h0);
    end
    cyc(1'b1, 4'h0, 4'h0);
    cyc(1'b0, 4'b0001, 4'b0001);
    chk("mid_write0", wr4, 4'b0001);
    cyc(1'b0, 4'h0, 4'h0);
    chk("mid_ready_t1", rdy4, 4'h0);
    cyc(1'b1, 4'h0, 4'h0);
    chk("mid_ready_t2", rdy4, 4'h0);
    for (int i = 3; i <= 6; i++) begin
      cyc(1'b0, 4'h0, 4'h0);
      chk($sformatf("mid_ready_t%0d", i), rdy4, 4'h0);
    end
    cyc(1'b0, 4'hF, 4'h0);
    chk("mid_restart_read", rd4, 4'b0001);
    chk("mid_restart_gid", gid4, 2'd0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, N'($urandom), N'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rw_ready_seq.md
Name: rw_ready_seq

Overview:
- Parametrised successor of the single-channel read/write/ready sequencer.
- Arbitrates N request channels round-robin and issues at most one read or write strobe per cycle.
- Raises a per-channel ready exactly READY_LAT cycles after each write.
- Serves as a formal/SVA test subject: properties are embedded and optional, and the port names match the existing property modules for `bind ... (.*)`.

Parameters:
- CHANNELS, 4: number of request channels. Legal range 2..16.
- READY_LAT, 1: cycles from a write strobe to the matching ready. Legal range 1..8. A value of 1 gives the original write |=> ready behaviour.
- ID_W, $clog2(CHANNELS): width of grant_id. Derived; not to be overridden.

Ports:
- clock  in  1  single clock; everything is posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  CHANNELS  per-channel request, level-sensitive.
- ctrl  in  CHANNELS  per-channel direction, sampled with req: 1 = write, 0 = read.
- read  out  CHANNELS  registered read strobe, one cycle.
- write  out  CHANNELS  registered write strobe, one cycle.
- ready  out  CHANNELS  registered ready, asserted READY_LAT cycles after write[i].
- grant_id  out  ID_W  index of the channel granted in the current strobe cycle.
- active  out  1  high when any read or write strobe is asserted this cycle.

Behaviour:
- Reset: a synchronous reset (reset high at a clock edge) forces the following.
  - read, write, ready, grant_id and active go to 0.
  - The round-robin pointer goes to 0.
  - All ready delay pipelines are cleared.
- Reset mid-operation: pending readies are dropped and never appear.
- Arbitration, evaluated combinationally each cycle on req:
  - Search starts at pointer p and wraps mod CHANNELS.
  - The first channel k with req[k]=1 wins.
  - If no req bit is set, there is no grant.
- Strobe generation, registered with latency 1:
  - If k is granted in cycle t, then at t+1: write[k]=ctrl[k]@t, read[k]=!ctrl[k]@t, grant_id=k, active=1.
  - All other bits of read and write are 0.
  - With no grant in cycle t: read=0, write=0, active=0 and grant_id holds its last value at t+1.
- Pointer update:
  - After a grant to k, p <= (k+1) mod CHANNELS. The wrap from CHANNELS-1 goes to 0.
  - With no grant, p holds.
- Invariants, checked every cycle:
  - (read | write) is onehot0.
  - read & write == 0, bitwise.
- Ready pipeline:
  - Each channel has a READY_LAT-deep shift register fed by write[i].
  - ready[i] at cycle t+READY_LAT equals write[i] at t.
  - Back-to-back writes to the same channel produce back-to-back readies. There is no merging and no backpressure.
- Simultaneous events:
  - A ready for channel i may coincide with a new read or write strobe on i or any other channel; all are independent.
  - A req that is held while not granted is not latched. Requesters keep req high until they see their own strobe, and may drop it any time.
- ctrl without req is ignored. The original idle-read behaviour, read = !ctrl, is intentionally removed.

Optional Feature:
- Macro: RW_SEQ_ASSERT_EN.
- When defined, the module contains concurrent assertions, all clocked @(posedge clock) and disabled iff (reset):
  - a_onehot: $onehot0(read | write).
  - a_rw: !(|(read & write)).
  - a_wr: one per channel, write[i] |-> ##READY_LAT ready[i].
  - a_rdy: one per channel, ready[i] |-> $past(write[i], READY_LAT).
  - a_fair: one per channel, req[i] held for CHANNELS cycles implies (read[i] | write[i]) within that window.
  - a_gid: active |-> (read[grant_id] | write[grant_id]).
- When undefined: no assertion code, identical ports and identical RTL behaviour.

Test Plan:
- Reset, then idle: reset high for 2 cycles with req=4'hF, then low with req=0. Required: all outputs 0 throughout, and active=0 for 10 cycles.
- Single writer: CHANNELS=4, READY_LAT=1; req=4'b0100, ctrl=4'b0100 for 1 cycle at t. Required: write=4'b0100, grant_id=2 at t+1; ready=4'b0100 at t+2 only.
- Round-robin wrap: req=4'hF, ctrl=0 held. Required: read sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and read&write==0 every cycle.
- Latency and back-to-back: READY_LAT=3; req[1]=ctrl[1]=1 for 3 cycles starting at t, others 0. Required: write[1] at t+1..t+3; ready[1] at t+4..t+6.
- Reset mid-flight: READY_LAT=4; write[0] strobes at t; reset at t+2. Required: ready[0] stays 0 through t+6; the pointer restarts at 0, so the next req=4'hF grants channel 0.
- Formal: with RW_SEQ_ASSERT_EN, prove all assertions at CHANNELS=3, READY_LAT=2. Forcing the ready pipe one stage short makes a_wr fail.
